// File: rtl/qnna_pkg.sv
// rtl/qnna_pkg.sv - shared register map, bit indices, FSM states and output quantizer
package qnna_pkg;

   localparam logic [11:0] OFF_CTRL     = 12'h000;
   localparam logic [11:0] OFF_STATUS   = 12'h004;
   localparam logic [11:0] OFF_LEN      = 12'h008;
   localparam logic [11:0] OFF_SHIFT    = 12'h00C;
   localparam logic [11:0] OFF_RESULT   = 12'h010;
   localparam logic [11:0] OFF_RESULT_Q = 12'h014;
   localparam logic [11:0] OFF_CYCLES   = 12'h018;
   localparam logic [11:0] OFF_OPS      = 12'h01C;
   localparam logic [11:0] IN_BASE      = 12'h400;
   localparam logic [11:0] WT_BASE      = 12'h800;

   localparam int CTRL_START   = 0;
   localparam int CTRL_IRQ_EN  = 1;
   localparam int CTRL_RELU_EN = 2;
   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ERR     = 2;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ACCUM, S_FINAL} state_t;

   // Arithmetic shift, optional ReLU, then clamp to int8 and sign-extend.
   function automatic logic [31:0] quantize(input logic [31:0] acc, input logic [4:0] shift,
                                            input logic relu);
      logic signed [31:0] v;
      v = $signed(acc) >>> shift;
      if (relu && v < 0) v = '0;
      if (v > 32'sd127) v = 32'sd127;
      else if (v < -32'sd128) v = -32'sd128;
      return v;
   endfunction

endpackage

// File: rtl/qnna_mac_array.sv
// rtl/qnna_mac_array.sv - combinational int8 dot product of one word pair
module qnna_mac_array #(
   parameter int MAC_SIZE   = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] w,
   output logic [31:0]           sum
);

   logic signed [15:0] prod [MAC_SIZE];

   always_comb begin
      sum = '0;
      for (int j = 0; j < MAC_SIZE; j++) begin
         prod[j] = $signed({{8{a[8*j+7]}}, a[8*j +: 8]}) * $signed({{8{w[8*j+7]}}, w[8*j +: 8]});
         sum = sum + {{16{prod[j][15]}}, prod[j]};
      end
   end

endmodule

// File: rtl/qnna_top.sv
// rtl/qnna_top.sv - Wishbone QNNA slave: register file, operand buffers and MAC sequencer
module qnna_top
   import qnna_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MAC_SIZE     = 4,
   parameter int BUFFER_DEPTH = 256
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   input  logic                    wb_we_i,
   input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_cyc_i,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,
   output logic                    irq_o
);

   localparam int AW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam logic [9:0] MAX_LEN = 10'(BUFFER_DEPTH);

   logic [11:0]           off;
   logic                  req, wr, reg_wr, is_in, is_wt, is_reg, busy;
   logic                  irq_en, relu_en, done, err, start_pend;
   logic [8:0]            len, cnt;
   logic [4:0]            shift;
   logic [31:0]           result, result_q, cycles, ops, lane_sum, reg_mux;
   logic [DATA_WIDTH-1:0] in_q, wt_q, reg_rdata;
   logic [DATA_WIDTH-1:0] in_mem [BUFFER_DEPTH];
   logic [DATA_WIDTH-1:0] wt_mem [BUFFER_DEPTH];
   logic [AW-1:0]         ram_addr, fsm_addr;
   logic [1:0]            rd_sel;
   state_t                state, state_nxt;
   logic                  unused_adr;

   assign off        = wb_adr_i[11:0];
   assign unused_adr = ^{wb_adr_i[ADDR_WIDTH-1:12], wb_adr_i[1:0]};
   assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
   assign is_in      = (off[11:10] == IN_BASE[11:10]);
   assign is_wt      = (off[11:10] == WT_BASE[11:10]);
   assign is_reg     = (off[11:5] == OFF_CTRL[11:5]);
   assign wr         = req & wb_we_i;
   assign reg_wr     = wr & is_reg;
   assign busy       = (state != S_IDLE);
   assign irq_o      = done & irq_en;
   assign ram_addr   = busy ? fsm_addr : off[2 +: AW];

   // Single-port buffers: the sequencer owns the address while busy, bus writes are dropped.
   always_ff @(posedge wb_clk_i) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
         if (wr && is_in && !busy && wb_sel_i[b]) in_mem[ram_addr][8*b +: 8] <= wb_dat_i[8*b +: 8];
         if (wr && is_wt && !busy && wb_sel_i[b]) wt_mem[ram_addr][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
      in_q <= in_mem[ram_addr];
      wt_q <= wt_mem[ram_addr];
   end

   qnna_mac_array #(.MAC_SIZE(MAC_SIZE), .DATA_WIDTH(DATA_WIDTH)) u_mac (
      .a   (in_q),
      .w   (wt_q),
      .sum (lane_sum)
   );

   always_comb begin
      reg_mux = '0;
      if (is_reg) begin
         case (off[4:2])
            3'd0: reg_mux = {29'd0, relu_en, irq_en, 1'b0};
            3'd1: reg_mux = {29'd0, err, done, busy};
            3'd2: reg_mux = {23'd0, len};
            3'd3: reg_mux = {27'd0, shift};
            3'd4: reg_mux = result;
            3'd5: reg_mux = result_q;
            3'd6: reg_mux = cycles;
            default: reg_mux = ops;
         endcase
      end
   end

   assign wb_dat_o = !wb_ack_o ? '0 : rd_sel[0] ? in_q : rd_sel[1] ? wt_q : reg_rdata;

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         wb_ack_o  <= 1'b0;
         wb_err_o  <= 1'b0;
         rd_sel    <= '0;
         reg_rdata <= '0;
      end else begin
         wb_ack_o  <= req & (is_reg | is_in | is_wt);
         wb_err_o  <= req & ~(is_reg | is_in | is_wt);
         rd_sel    <= (req & ~wb_we_i) ? {is_wt, is_in} : 2'b00;
         reg_rdata <= (req & ~wb_we_i) ? DATA_WIDTH'(reg_mux) : '0;
      end
   end

   always_comb begin
      state_nxt = state;
      fsm_addr  = AW'(cnt + 9'd1);
      case (state)
         S_IDLE:  if (start_pend) state_nxt = S_FETCH;
         S_FETCH: begin
            state_nxt = S_ACCUM;
            fsm_addr  = '0;
         end
         S_ACCUM: if (cnt == len - 9'd1) state_nxt = S_FINAL;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state      <= S_IDLE;
         irq_en     <= 1'b0;
         relu_en    <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         start_pend <= 1'b0;
         len        <= '0;
         shift      <= '0;
         cnt        <= '0;
         result     <= '0;
         result_q   <= '0;
         cycles     <= '0;
         ops        <= '0;
      end else begin
         state <= state_nxt;
         if (reg_wr && off[4:2] == OFF_CTRL[4:2]) begin
            irq_en  <= wb_dat_i[CTRL_IRQ_EN];
            relu_en <= wb_dat_i[CTRL_RELU_EN];
            if (wb_dat_i[CTRL_START] && !busy) begin
               if (len == 9'd0 || {1'b0, len} > MAX_LEN) err <= 1'b1;
               else start_pend <= 1'b1;
            end
         end
         if (reg_wr && off[4:2] == OFF_STATUS[4:2]) begin
            if (wb_dat_i[STAT_DONE]) done <= 1'b0;
            if (wb_dat_i[STAT_ERR]) err <= 1'b0;
         end
         if (reg_wr && off[4:2] == OFF_LEN[4:2]) len <= wb_dat_i[8:0];
         if (reg_wr && off[4:2] == OFF_SHIFT[4:2]) shift <= wb_dat_i[4:0];
         if (busy) cycles <= cycles + 32'd1;
         case (state)
            S_IDLE: if (start_pend) begin
               start_pend <= 1'b0;
               done       <= 1'b0;
               err        <= 1'b0;
               result     <= '0;
               cycles     <= '0;
               ops        <= '0;
               cnt        <= '0;
            end
            S_ACCUM: begin
               result <= result + lane_sum;
               cnt    <= cnt + 9'd1;
            end
            S_FINAL: begin
               result_q <= quantize(result, shift, relu_en);
               ops      <= 32'(len) * 32'(MAC_SIZE);
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_qnna_top.sv
// tb/tb_qnna_top.sv - directed self-checking bench for qnna_top
module tb_qnna_top;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] adr = '0, dat_w = '0, dat_r;
   logic [3:0]  sel = '0;
   logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
   logic        ack, err, irq;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   qnna_top dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst_n),
      .wb_adr_i (adr),
      .wb_dat_i (dat_w),
      .wb_dat_o (dat_r),
      .wb_we_i  (we),
      .wb_sel_i (sel),
      .wb_stb_i (stb),
      .wb_cyc_i (cyc),
      .wb_ack_o (ack),
      .wb_err_o (err),
      .irq_o    (irq)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] w;
      logic [4:0]  shift;
      logic        relu;
      logic [31:0] res;
      logic [31:0] q;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic got_ack, output logic got_err);
      adr = a; dat_w = d; we = w; sel = s; cyc = 1'b1; stb = 1'b1;
      got_ack = 1'b0; got_err = 1'b0; rd = '0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ack || err) begin
            got_ack = ack; got_err = err; rd = dat_r;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (!got_ack && !got_err) begin
         checks++; errors++;
         $display("FAIL bus_timeout: no response at 0x%08h", a);
      end
   endtask

   task automatic wr_sel(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r; logic k, e;
      bus(1'b1, a, d, s, r, k, e);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wr_sel(a, d, 4'hF);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      logic k, e;
      bus(1'b0, a, 32'h0, 4'hF, d, k, e);
   endtask

   task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      check(name, d, exp);
   endtask

   task automatic wait_done();
      logic [31:0] st;
      for (int i = 0; i < 1000; i++) begin
         rd(32'h8000_0004, st);
         if (st[1]) return;
      end
      checks++; errors++;
      $display("FAIL done_timeout: STATUS never showed DONE, last 0x%08h", st);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic        k, e;

      vecs[0] = '{32'h04030201, 32'h01010101, 5'd0, 1'b0, 32'd10,         32'd10};
      vecs[1] = '{32'hFFFFFFFF, 32'h7F7F7F7F, 5'd0, 1'b0, 32'hFFFFFE04,   32'hFFFFFF80};
      vecs[2] = '{32'hFFFFFFFF, 32'h7F7F7F7F, 5'd0, 1'b1, 32'hFFFFFE04,   32'h00000000};
      vecs[3] = '{32'h80808080, 32'h80808080, 5'd8, 1'b0, 32'h00010000,   32'h0000007F};
      vecs[4] = '{32'h0A0B0C0D, 32'h02FFFE01, 5'd0, 1'b0, 32'hFFFFFFFE,   32'hFFFFFFFE};
      vecs[5] = '{32'h0A0B0C0D, 32'h02FFFE01, 5'd1, 1'b0, 32'hFFFFFFFE,   32'hFFFFFFFF};
      vecs[6] = '{32'h10101010, 32'h10101010, 5'd3, 1'b0, 32'd1024,       32'h0000007F};
      vecs[7] = '{32'h10101010, 32'h10101010, 5'd4, 1'b0, 32'd1024,       32'h00000040};
      vecs[8] = '{32'h7F7F7F7F, 32'h81818181, 5'd9, 1'b0, 32'hFFFF03FC,   32'hFFFFFF81};

      // reset state
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset_ack", {31'd0, ack}, 32'd0);
      check("reset_err", {31'd0, err}, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      check("reset_dat", dat_r, 32'd0);
      rd_check("reset_status", 32'h8000_0004, 32'h0);
      rd_check("reset_ctrl", 32'h8000_0000, 32'h0);
      bus(1'b0, 32'h8000_0020, 32'h0, 4'hF, d, k, e);
      check("unmapped_err", {31'd0, e}, 32'd1);
      check("unmapped_noack", {31'd0, k}, 32'd0);
      check("unmapped_data", d, 32'd0);
      @(posedge clk); #1;
      check("unmapped_err_one_cycle", {31'd0, err}, 32'd0);

      // single-word dot products
      for (int i = 0; i < 9; i++) begin
         wr(32'h8000_0400, vecs[i].a);
         wr(32'h8000_0800, vecs[i].w);
         wr(32'h8000_0008, 32'd1);
         wr(32'h8000_000C, {27'd0, vecs[i].shift});
         wr(32'h8000_0000, {29'd0, vecs[i].relu, 2'b01});
         wait_done();
         rd_check($sformatf("v%0d_result", i), 32'h8000_0010, vecs[i].res);
         rd_check($sformatf("v%0d_result_q", i), 32'h8000_0014, vecs[i].q);
         rd_check($sformatf("v%0d_cycles", i), 32'h8000_0018, 32'd3);
         rd_check($sformatf("v%0d_ops", i), 32'h8000_001C, 32'd4);
         rd_check($sformatf("v%0d_status", i), 32'h8000_0004, 32'h2);
      end

      // byte enables on buffers, register writes ignore sel
      wr(32'h8000_0404, 32'hAABBCCDD);
      wr_sel(32'h8000_0404, 32'h11223344, 4'b0101);
      rd_check("buf_byte_enable", 32'h8000_0404, 32'hAA22CC44);
      rd_check("wt_readback", 32'h8000_0800, 32'h81818181);
      wr_sel(32'h8000_0008, 32'd5, 4'b0000);
      rd_check("reg_ignores_sel", 32'h8000_0008, 32'd5);

      // full-length run
      for (int i = 0; i < 256; i++) begin
         wr(32'h8000_0400 + 32'(4*i), 32'h01010101);
         wr(32'h8000_0800 + 32'(4*i), 32'h01010101);
      end
      wr(32'h8000_0008, 32'd256);
      wr(32'h8000_000C, 32'd2);
      wr(32'h8000_0000, 32'h1);
      rd_check("full_busy", 32'h8000_0004, 32'h1);
      wr(32'h8000_0400, 32'h7F7F7F7F);
      wait_done();
      rd_check("full_result", 32'h8000_0010, 32'd1024);
      rd_check("full_result_q", 32'h8000_0014, 32'h7F);
      rd_check("full_cycles", 32'h8000_0018, 32'd258);
      rd_check("full_ops", 32'h8000_001C, 32'd1024);
      rd_check("busy_write_dropped", 32'h8000_0400, 32'h01010101);

      // interrupt and errors
      wr(32'h8000_0008, 32'd1);
      wr(32'h8000_0000, 32'h3);
      wait_done();
      check("irq_set", {31'd0, irq}, 32'd1);
      wr(32'h8000_0004, 32'h2);
      check("irq_cleared", {31'd0, irq}, 32'd0);
      rd_check("status_after_w1c", 32'h8000_0004, 32'h0);
      wr(32'h8000_0008, 32'd0);
      wr(32'h8000_0000, 32'h3);
      rd_check("len0_err", 32'h8000_0004, 32'h4);
      wr(32'h8000_0004, 32'h4);
      rd_check("err_cleared", 32'h8000_0004, 32'h0);
      wr(32'h8000_0008, 32'd257);
      wr(32'h8000_0000, 32'h1);
      rd_check("len257_err", 32'h8000_0004, 32'h4);
      wr(32'h8000_0004, 32'h4);

      // reset mid-run
      wr(32'h8000_0008, 32'd256);
      wr(32'h8000_0000, 32'h3);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_irq", {31'd0, irq}, 32'd0);
      check("midrst_ack", {31'd0, ack}, 32'd0);
      check("midrst_busy", {31'd0, dut.busy}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rd_check("midrst_status", 32'h8000_0004, 32'h0);
      rd_check("midrst_ctrl", 32'h8000_0000, 32'h0);
      rd_check("midrst_cycles", 32'h8000_0018, 32'h0);
      rd_check("midrst_result", 32'h8000_0010, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/qnna_top.md
# qnna_top

Quantized neural-network accelerator (QNNA) slave on the SoC Wishbone bus, in the 4 KB window at 0x8000_0000 and selected by the interconnect. It holds an int8 input buffer and an int8 weight buffer, plus a register file. On START it computes a signed int8 dot product over MAC_SIZE lanes per cycle into a 32-bit accumulator, applies shift, optional ReLU and int8 saturation, and raises an interrupt to the CPU.

## Interface
- ADDR_WIDTH, 32, Wishbone address width; only bits [11:0] are decoded.
- DATA_WIDTH, 32, Wishbone data width; MAC_SIZE*8 must equal DATA_WIDTH.
- MAC_SIZE, 4, int8 lanes per word and MACs per cycle.
- BUFFER_DEPTH, 256, words per buffer; maximum 256.
- wb_clk_i  in  1  single clock; all logic is rising-edge.
- wb_rst_i  in  1  reset, asynchronous assert, active-low.
- wb_adr_i  in  ADDR_WIDTH  byte address.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_dat_o  out  DATA_WIDTH  read data; valid while wb_ack_o=1.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  DATA_WIDTH/8  byte enables.
- wb_stb_i, wb_cyc_i  in  1  strobe and cycle.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  error response for unmapped offsets.
- irq_o  out  1  level interrupt, equal to DONE & IRQ_EN.

## Operation
Register map (offset = wb_adr_i[11:0]):
- 0x000 CTRL
  - bit0 START: write-1 pulse, reads back 0.
  - bit1 IRQ_EN.
  - bit2 RELU_EN.
- 0x004 STATUS
  - bit0 BUSY: read-only.
  - bit1 DONE: write-1-to-clear.
  - bit2 ERR: write-1-to-clear.
- 0x008 LEN [8:0]: number of words to process.
- 0x00C SHIFT [4:0]: right-shift amount.
- 0x010 RESULT: read-only int32 accumulator.
- 0x014 RESULT_Q: read-only, sign-extended int8.
- 0x018 CYCLES: read-only busy-cycle count of the last operation.
- 0x01C OPS: read-only MAC count of the last operation.
- 0x400–0x7FF: input buffer, word i at 0x400+4i.
- 0x800–0xBFF: weight buffer, word i at 0x800+4i.
- Any other offset: wb_err_o instead of ack; write has no effect, read data 0.

Register and buffer access rules:
- Register writes ignore wb_sel_i.
- Buffer writes honour wb_sel_i per byte.
- Buffer writes while BUSY are acked and dropped.
- Buffer reads return stored data.
- Element j of a word is bits [8j+7:8j], signed.

START handling:
- START with BUSY=1: ignored.
- START with LEN=0 or LEN>BUFFER_DEPTH: sets ERR, does not set BUSY or DONE.
- Valid START:
  - Clears DONE, ERR, RESULT, CYCLES and OPS.
  - Sets BUSY.

FSM states: IDLE → FETCH → ACCUM → FINAL → IDLE.
- FETCH issues the read of word 0.
- ACCUM: each cycle adds the sum of MAC_SIZE products a_j*w_j for the current word and issues the next read, for LEN cycles.
- FINAL computes RESULT_Q, sets DONE and clears BUSY.
- Arithmetic:
  - Each product is 16-bit signed; each lane sum is sign-extended to 32 bits.
  - The accumulator wraps modulo 2^32.
  - RESULT_Q = sat8(relu?(max(RESULT>>>SHIFT, 0)) : RESULT>>>SHIFT), using an arithmetic shift.
  - sat8 clamps to the range [-128, 127].
- CYCLES increments every BUSY cycle.
- OPS = LEN*MAC_SIZE.

## Timing
- Reset values:
  - All registers 0; FSM in IDLE.
  - wb_ack_o=0, wb_err_o=0, wb_dat_o=0, irq_o=0.
  - Buffer contents are not cleared.
- Bus handshake:
  - wb_ack_o (or wb_err_o) asserts one cycle after wb_cyc_i&wb_stb_i with ack/err currently low.
  - The response is held for exactly one cycle.
  - Back-to-back access therefore costs 2 cycles.
- The write takes effect on the cycle ack is driven.
- Compute timing:
  - BUSY rises the cycle after the START ack.
  - BUSY lasts exactly LEN+2 cycles.
  - DONE and irq_o rise in the cycle BUSY falls.
- Clearing DONE drops irq_o the cycle after the ack.
- Asserting reset mid-operation clears BUSY, DONE and irq_o immediately and asynchronously.

## Structure
- Shared package `qnna_pkg`:
  - Register offsets and buffer base offsets.
  - CTRL and STATUS bit indices.
  - FSM state enum.
- Sub-module `qnna_mac_array`: combinational MAC_SIZE-lane int8 dot-product adder tree producing the 32-bit lane sum.
- Buffers are inferred single-port synchronous RAMs inside the top level.

## Test plan
- Reset test:
  - Stimulus: release reset.
  - Response: STATUS=0, CTRL read 0, irq_o=0, wb_ack_o=0.
  - Stimulus: read 0x020.
  - Response: one-cycle wb_err_o, no ack.
- Basic dot product:
  - Stimulus: input[0]=0x04030201, weight[0]=0x01010101, LEN=1, SHIFT=0, START.
  - Response: BUSY for 3 cycles; RESULT=10, RESULT_Q=10, DONE=1, OPS=4, CYCLES=3.
- Signed saturation:
  - Stimulus: input[0]=0xFFFFFFFF, weight[0]=0x7F7F7F7F, LEN=1.
  - Response: RESULT=0xFFFFFE04 (-508), RESULT_Q=0xFFFFFF80.
  - Stimulus: repeat with RELU_EN=1.
  - Response: RESULT_Q=0.
- Shift and full-length run:
  - Stimulus: LEN=256, all bytes 0x01, SHIFT=2.
  - Response: RESULT=1024, RESULT_Q=127, CYCLES=258, OPS=1024.
- Interrupt and errors:
  - Stimulus: IRQ_EN=1, complete a run.
  - Response: irq_o=1.
  - Stimulus: write 0x2 to STATUS.
  - Response: irq_o=0.
  - Stimulus: LEN=0 then START.
  - Response: ERR=1, BUSY never set.
- Reset mid-run:
  - Stimulus: assert reset 10 cycles into a LEN=256 run.
  - Response: BUSY=0 and irq_o=0 immediately; STATUS=0 after release.
